// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - byte-enable patterns, FSM encoding and lane helpers
package mem_access_unit_pkg;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_B1  = 4'b0010;
  localparam logic [3:0] BE_B2  = 4'b0100;
  localparam logic [3:0] BE_B3  = 4'b1000;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Halves and words must be naturally aligned; single bytes may sit anywhere.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] off);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3: be_legal = 1'b1;
      BE_HLO, BE_W:               be_legal = (off == 2'b00);
      BE_HHI:                     be_legal = (off == 2'b10);
      default:                    be_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [3:0] be, input logic [31:0] wdata);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3: lane_replicate = {4{wdata[7:0]}};
      BE_HLO, BE_HHI:             lane_replicate = {2{wdata[15:0]}};
      default:                    lane_replicate = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// rtl/mem_access_unit_load_extend.sv - lane select and sign/zero extension of a DM word
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  be,
  input  logic        rd_signed,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = word;
    case (be)
      BE_B0:  result = {{24{rd_signed & word[7]}},  word[7:0]};
      BE_B1:  result = {{24{rd_signed & word[15]}}, word[15:8]};
      BE_B2:  result = {{24{rd_signed & word[23]}}, word[23:16]};
      BE_B3:  result = {{24{rd_signed & word[31]}}, word[31:24]};
      BE_HLO: result = {{16{rd_signed & word[15]}}, word[15:0]};
      BE_HHI: result = {{16{rd_signed & word[31]}}, word[31:16]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multicycle load/store stage driving a fixed-latency data memory
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int AW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic          rd_signed,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic          dm_en,
  output logic [3:0]    dm_we,
  output logic [AW-3:0] dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata
);

  localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

  state_t      state, state_next;
  logic        we_q, rd_signed_q;
  logic [3:0]  be_q;
  logic [1:0]  cnt;
  logic        accept, legal;
  logic [31:0] ext_data;

  assign accept = (state == ST_IDLE) && start;
  assign legal  = be_legal(be, addr[1:0]);
  assign busy   = (state != ST_IDLE);

  load_extend u_load_extend (
    .be        (be_q),
    .rd_signed (rd_signed_q),
    .word      (dm_rdata),
    .result    (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = legal ? ST_ISSUE : ST_DONE;
      ST_ISSUE: state_next = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (cnt == 2'd0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // DM strobes are registered from the accept decision so they line up with ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= '0;
      dm_en       <= 1'b0;
      dm_we       <= 4'b0000;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      rd_signed_q <= 1'b0;
      cnt         <= 2'd0;
    end else begin
      done  <= (state_next == ST_DONE);
      err   <= accept & ~legal;
      dm_en <= accept & legal;
      dm_we <= (accept & legal & we) ? be : 4'b0000;
      if (accept) begin
        we_q        <= we;
        be_q        <= be;
        rd_signed_q <= rd_signed;
      end
      if (accept & legal) begin
        dm_addr  <= addr[AW-1:2];
        dm_wdata <= lane_replicate(be, wdata);
      end
      if (state == ST_ISSUE)
        cnt <= CNT_INIT;
      else if (state == ST_WAIT && cnt != 2'd0)
        cnt <= cnt - 2'd1;
      if (state == ST_WAIT && cnt == 2'd0)
        rdata <= ext_data;
    end
  end

endmodule
